// File: rtl/id_opfetch_if.sv
// id_opfetch_if: registered decode/operand bundle handed from id_opfetch to EX
interface id_opfetch_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
);
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         aluop_o;
  logic [2:0]         alusel_o;
  logic [DATA_W-1:0]  reg1_o;
  logic [DATA_W-1:0]  reg2_o;
  logic [RADDR_W-1:0] wd_o;
  logic               wreg_o;
  logic [31:0]        pc_o;
  logic               inst_inv_o;
  modport master (
    output out_valid, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, pc_o, inst_inv_o,
    input  out_ready
  );
  modport slave (
    input  out_valid, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, pc_o, inst_inv_o,
    output out_ready
  );
endinterface

// File: rtl/id_opfetch.sv
// id_opfetch: decode + forwarded operand fetch with hazard stall; optional ID_STALL_CNT_EN adds stall_cnt_o
module id_opfetch #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int FWD_CH  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               pc_i,
  input  logic [31:0]               inst_i,
  input  logic [FWD_CH-1:0]         fwd_wreg,
  input  logic [FWD_CH-1:0]         fwd_pend,
  input  logic [FWD_CH*RADDR_W-1:0] fwd_waddr,
  input  logic [FWD_CH*DATA_W-1:0]  fwd_wdata,
  output logic                      reg1_read_o,
  output logic                      reg2_read_o,
  output logic [RADDR_W-1:0]        reg1_addr_o,
  output logic [RADDR_W-1:0]        reg2_addr_o,
  input  logic [DATA_W-1:0]         reg1_data_i,
  input  logic [DATA_W-1:0]         reg2_data_i,
`ifdef ID_STALL_CNT_EN
  output logic [31:0]               stall_cnt_o,
`endif
  id_opfetch_if.master              ex
);
  localparam logic [7:0] OP_NOP = 8'h00, OP_OR = 8'h25, OP_SLL = 8'h7C;
  localparam logic [2:0] RES_NOP = 3'd0, RES_LOGIC = 3'd1, RES_SHIFT = 3'd2;
  logic [5:0]         opc, fn;
  logic [RADDR_W-1:0] rs, rt, rd, a1, a2, wd;
  logic               re1, re2, inv, wreg, p1, p2, hazard;
  logic [DATA_W-1:0]  imm1, imm2, v1, v2, op1, op2;
  logic [7:0]         aluop;
  logic [2:0]         alusel;
  assign opc = inst_i[31:26];
  assign fn  = inst_i[5:0];
  assign rs  = RADDR_W'(inst_i[25:21]);
  assign rt  = RADDR_W'(inst_i[20:16]);
  assign rd  = RADDR_W'(inst_i[15:11]);
  // decode: source selection, immediates, destination and ALU codes
  always_comb begin
    re1 = 1'b0;
    re2 = 1'b0;
    a1 = rs;
    a2 = rt;
    imm1 = '0;
    imm2 = '0;
    wd = '0;
    aluop = OP_NOP;
    alusel = RES_NOP;
    inv = 1'b1;
    if (opc == 6'h00 && fn[5:2] == 4'b1001) begin
      re1 = 1'b1;
      re2 = 1'b1;
      wd = rd;
      aluop = {2'b00, fn};
      alusel = RES_LOGIC;
      inv = 1'b0;
    end else if (opc == 6'h00 && fn[5:3] == 3'b000 && fn[1:0] != 2'b01) begin
      re1 = 1'b1;
      a1 = rt;
      re2 = fn[2];
      a2 = rs;
      imm2 = DATA_W'(inst_i[10:6]);
      wd = rd;
      aluop = (fn[1:0] == 2'b00) ? OP_SLL : {6'b0, fn[1:0]};
      alusel = RES_SHIFT;
      inv = 1'b0;
    end else if (opc[5:2] == 4'b0011) begin
      re1 = opc[1:0] != 2'b11;
      imm1 = (opc[1:0] == 2'b11) ? DATA_W'({inst_i[15:0], 16'h0}) : '0;
      imm2 = (opc[1:0] == 2'b11) ? '0 : DATA_W'(inst_i[15:0]);
      wd = rt;
      aluop = (opc[1:0] == 2'b11) ? OP_OR : {6'b001001, opc[1:0]};
      alusel = RES_LOGIC;
      inv = 1'b0;
    end
  end
  assign wreg = !inv && wd != '0;
  // forwarding: scan oldest to youngest so the lowest-index match wins
  always_comb begin
    v1 = reg1_data_i;
    v2 = reg2_data_i;
    p1 = 1'b0;
    p2 = 1'b0;
    for (int c = FWD_CH - 1; c >= 0; c--) begin
      if (fwd_wreg[c] && fwd_waddr[c*RADDR_W +: RADDR_W] == a1) begin
        v1 = fwd_wdata[c*DATA_W +: DATA_W];
        p1 = fwd_pend[c];
      end
      if (fwd_wreg[c] && fwd_waddr[c*RADDR_W +: RADDR_W] == a2) begin
        v2 = fwd_wdata[c*DATA_W +: DATA_W];
        p2 = fwd_pend[c];
      end
    end
  end
  assign op1 = !re1 ? imm1 : (a1 == '0) ? '0 : v1;
  assign op2 = !re2 ? imm2 : (a2 == '0) ? '0 : v2;
  assign hazard = (re1 && a1 != '0 && p1) || (re2 && a2 != '0 && p2);
  assign reg1_read_o = re1 && !rst;
  assign reg2_read_o = re2 && !rst;
  assign reg1_addr_o = reg1_read_o ? a1 : '0;
  assign reg2_addr_o = reg2_read_o ? a2 : '0;
  assign in_ready = !rst && !hazard && (!ex.out_valid || ex.out_ready) && !flush;
  // output register: flush beats accept, accept beats drain; data holds when not loading
  always_ff @(posedge clk) begin
    if (rst) begin
      ex.out_valid <= 1'b0;
      ex.aluop_o <= OP_NOP;
      ex.alusel_o <= RES_NOP;
      ex.reg1_o <= '0;
      ex.reg2_o <= '0;
      ex.wd_o <= '0;
      ex.wreg_o <= 1'b0;
      ex.pc_o <= '0;
      ex.inst_inv_o <= 1'b0;
    end else if (flush) begin
      ex.out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      ex.out_valid <= 1'b1;
      ex.aluop_o <= aluop;
      ex.alusel_o <= alusel;
      ex.reg1_o <= op1;
      ex.reg2_o <= op2;
      ex.wd_o <= wd;
      ex.wreg_o <= wreg;
      ex.pc_o <= pc_i;
      ex.inst_inv_o <= inv;
    end else if (ex.out_ready) begin
      ex.out_valid <= 1'b0;
    end
  end
`ifdef ID_STALL_CNT_EN
  // saturating count of cycles a valid instruction waits on a pending result
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_o <= '0;
    else if (in_valid && hazard && !flush && ~&stall_cnt_o) stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif
endmodule

// File: doc/id_opfetch.md
# id_opfetch

Parametrised decode/operand-fetch stage sitting between the IF/ID register and EX. It decodes the logic/shift/immediate subset and selects operands from the regfile or from FWD_CH prioritised forwarding channels. It stalls on pending (not-yet-available) results and registers its outputs behind a valid/ready handshake toward EX. Flush support drops the in-flight instruction.

## Interface
- DATA_W, 32, operand/data width (≥16)
- RADDR_W, 5, register address width
- FWD_CH, 3, forwarding channels; channel 0 = youngest = highest priority
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard output register and current input
- in_valid  in  1  pc_i/inst_i valid
- in_ready  out  1  stage accepts input this cycle
- pc_i  in  32  instruction address
- inst_i  in  32  instruction word
- fwd_wreg  in  FWD_CH  channel c writes a register
- fwd_pend  in  FWD_CH  channel c result not yet available
- fwd_waddr  in  FWD_CH*RADDR_W  packed destination addresses
- fwd_wdata  in  FWD_CH*DATA_W  packed result data
- reg1_read_o, reg2_read_o  out  1  regfile read enables (combinational)
- reg1_addr_o, reg2_addr_o  out  RADDR_W  regfile read addresses (combinational)
- reg1_data_i, reg2_data_i  in  DATA_W  regfile read data, same cycle
- out_valid  out  1  registered outputs valid
- out_ready  in  1  EX consumes
- aluop_o  out  8  `EXE_*_OP` code
- alusel_o  out  3  `EXE_RES_*` code
- reg1_o, reg2_o  out  DATA_W  operands
- wd_o  out  RADDR_W  destination
- wreg_o  out  1  write enable
- pc_o  out  32  instruction address
- inst_inv_o  out  1  unrecognised instruction

## Operation
- Decode (rs=inst[25:21], rt=[20:16], rd=[15:11], sa=[10:6]):
  - SPECIAL funct AND/OR/XOR/NOR (0x24–0x27): read rs, rt; wd=rd; LOGIC.
  - SLL/SRL/SRA (0x00/0x02/0x03): read rt only; reg1=rt value, reg2={0,sa}; SHIFT.
  - SLLV/SRLV/SRAV (0x04/0x06/0x07): reg1=rt value, reg2=rs value; SHIFT ops.
  - ANDI/ORI/XORI (0x0C/0x0D/0x0E): read rs; reg2=zero-extended imm16; wd=rt.
  - LUI (0x0F): no reads; reg1={imm16,16'h0} (upper bits zero if DATA_W>32), reg2=0; OR op.
  - Anything else: aluop NOP, alusel NOP, wreg 0, inst_inv_o=1.
- wreg_o forced 0 when wd==0 (all-zero word = NOP, valid, no write).
- Operand select per source, when read enabled and addr≠0: lowest-index channel c with fwd_wreg[c] && waddr==addr wins; its data is used. If no match, regfile data. addr==0 always yields 0. Read disabled yields the immediate/sa value above.
- Hazard: winning channel has fwd_pend=1 → stall. Older matching channels are ignored.
- in_ready = !hazard && (!out_valid || out_ready) && !flush.
- Accept (in_valid && in_ready): output register loads decoded values and out_valid=1.
- Else if out_ready: out_valid=0. Data fields hold their values.
- flush: out_valid←0 next edge. flush overrides accept and hold.
- rst overrides all.

## Timing
- Latency is 1 cycle from accept to out_valid.
- Throughput is 1/cycle with no hazard and out_ready=1.
- Regfile/forward paths are combinational in the accepting cycle. Forward data is sampled at accept only.
- Reset values: out_valid 0, aluop_o `EXE_NOP_OP`, alusel_o `EXE_RES_NOP`, reg1_o/reg2_o 0, wd_o 0, wreg_o 0, pc_o 0, inst_inv_o 0, stall_cnt_o 0.
- During rst: reg*_read_o=0, reg*_addr_o=0, in_ready=0.
- Outputs stay stable while out_valid && !out_ready.
- Reset mid-hazard: pending instruction is dropped. Upstream re-presents it.

## Configuration
- ID_STALL_CNT_EN defined: adds output stall_cnt_o [31:0]. It increments each cycle with in_valid && hazard && !flush, saturates at 0xFFFFFFFF, and is cleared by rst.
- ID_STALL_CNT_EN undefined: port and counter are absent. Behaviour is otherwise identical.

## Test plan
- Reset, then ORI $1,$0,0x1234 with regfile returning 0 → next cycle out_valid=1, reg1=0, reg2=0x00001234, wd=1, wreg=1, OR/LOGIC.
- AND $3,$1,$2 with ch0 (wreg,addr 1,0xAA) and ch1 (wreg,addr 1,0xBB) → reg1=0xAA (ch0 priority); reg2 from regfile.
- ch0 wreg+pend addr 2, then XOR $4,$2,$5 → in_ready=0 and stall counter increments. Drop pend with data 0x55 → accepted, reg1=0x55.
- out_ready=0 for 3 cycles with in_valid held → outputs stable, in_ready=0. out_ready=1 → next instruction loads the following cycle.
- Inst 0x00000000 → wreg_o=0, inst_inv_o=0. Opcode 0x3F → inst_inv_o=1, wreg_o=0.
- flush asserted with in_valid and out_valid → next cycle out_valid=0, no accept. LUI $7,0xBEEF then → reg1=0xBEEF0000.
